// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_debounce
//
// Purpose: turns one raw, asynchronous, bouncy push-button into a clean
// one-cycle press pulse in the system clock domain.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   btn_raw  raw button level, active-high, asynchronous to clk
//   press    one-cycle pulse on each accepted rising edge of the button
//
// Pipeline from a clean raw rising edge first sampled at edge N:
//   N                   : first synchronizer stage captures the level
//   N+1                 : second synchronizer stage
//   N+1+DEBOUNCE_CYCLES : debounced level flips
//   N+2+DEBOUNCE_CYCLES : press pulse is high
// so the consumer reacts on edge N+3+DEBOUNCE_CYCLES.
// ---------------------------------------------------------------------------
module stopwatch_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; the flip happens on the
    // sample that would have made it DEBOUNCE_CYCLES.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic             press_q, press_d;

    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        level_dly_d = level_q;

        // Any sample that agrees with the accepted level throws away the
        // partial count, so a single bounce restarts the whole window.
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Only rising edges of the accepted level are events; releases are
        // deliberately silent.
        press_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
        end
    end

    assign press = press_q;

endmodule

// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Purpose: control sequencer for a two-digit 0-99 BCD stopwatch. Debounces
// the start/stop and lap/clear buttons, runs the IDLE/RUN/PAUSE/LAP/DONE
// state machine and produces one-cycle count enables, clears and lap loads
// for the counter and display path. Everything runs in the clk_50mhz domain.
//
// Ports:
//   clk_50mhz  system clock
//   rst        synchronous, active-high reset
//   btn_ss     raw start/stop button (asynchronous, active-high)
//   btn_lc     raw lap/clear button (asynchronous, active-high)
//   at_max     counter currently holds 99
//   cnt_tick   one-cycle count enable to the units counter
//   cnt_clr    one-cycle counter clear
//   lap_load   one-cycle pulse: display latches the current count
//   disp_hold  display shows the latched lap value instead of the live count
//   state      IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WRAP            = 0
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lc,
    input  logic       at_max,
    output logic       cnt_tick,
    output logic       cnt_clr,
    output logic       lap_load,
    output logic       disp_hold,
    output logic [2:0] state
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam bit STOP_AT_MAX = (WRAP == 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_LAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    logic ss_press;
    logic lc_press;

    stopwatch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_ss (
        .clk     (clk_50mhz),
        .rst     (rst),
        .btn_raw (btn_ss),
        .press   (ss_press)
    );

    stopwatch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_lc (
        .clk     (clk_50mhz),
        .rst     (rst),
        .btn_raw (btn_lc),
        .press   (lc_press)
    );

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cnt_tick_q, cnt_tick_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             lap_load_q, lap_load_d;
    logic             disp_hold_q, disp_hold_d;

    logic ss_ev;
    logic lc_ev;
    logic running;
    logic terminal;
    logic max_stop;

    always_comb begin
        // start/stop has priority: a lap/clear landing in the same cycle is
        // dropped rather than queued.
        ss_ev = ss_press;
        lc_ev = lc_press & ~ss_press;

        running  = (state_q == ST_RUN) || (state_q == ST_LAP);
        terminal = running && (div_q == DIV_LAST);
        max_stop = terminal && STOP_AT_MAX && at_max;

        state_d     = state_q;
        div_d       = div_q;
        cnt_clr_d   = 1'b0;
        lap_load_d  = 1'b0;
        disp_hold_d = disp_hold_q;

        // The divider advances on the current state only, so the cycle that
        // leaves RUN/LAP still counts and its terminal still ticks; PAUSE
        // simply freezes it, preserving phase across the pause.
        if (running) begin
            div_d = terminal ? '0 : div_q + 1'b1;
        end
        cnt_tick_d = terminal && !max_stop;

        unique case (state_q)
            ST_IDLE: begin
                if (ss_ev) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end else if (lc_ev) begin
                    cnt_clr_d = 1'b1;
                end
            end

            ST_RUN: begin
                // Hitting 99 overrides any button so the counter never
                // advances past its top value.
                if (max_stop) begin
                    state_d     = ST_DONE;
                    disp_hold_d = 1'b0;
                end else if (ss_ev) begin
                    state_d = ST_PAUSE;
                end else if (lc_ev) begin
                    state_d     = ST_LAP;
                    lap_load_d  = 1'b1;
                    disp_hold_d = 1'b1;
                end
            end

            ST_LAP: begin
                if (max_stop) begin
                    state_d     = ST_DONE;
                    disp_hold_d = 1'b0;
                end else if (ss_ev) begin
                    state_d     = ST_PAUSE;
                    disp_hold_d = 1'b0;
                end else if (lc_ev) begin
                    state_d     = ST_RUN;
                    disp_hold_d = 1'b0;
                end
            end

            ST_PAUSE: begin
                if (ss_ev) begin
                    state_d = ST_RUN;
                end else if (lc_ev) begin
                    state_d   = ST_IDLE;
                    cnt_clr_d = 1'b1;
                end
            end

            ST_DONE: begin
                disp_hold_d = 1'b0;
                if (lc_ev) begin
                    state_d   = ST_IDLE;
                    cnt_clr_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                disp_hold_d = 1'b0;
                cnt_tick_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            cnt_tick_q  <= 1'b0;
            cnt_clr_q   <= 1'b0;
            lap_load_q  <= 1'b0;
            disp_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_tick_q  <= cnt_tick_d;
            cnt_clr_q   <= cnt_clr_d;
            lap_load_q  <= lap_load_d;
            disp_hold_q <= disp_hold_d;
        end
    end

    assign cnt_tick  = cnt_tick_q;
    assign cnt_clr   = cnt_clr_q;
    assign lap_load  = lap_load_q;
    assign disp_hold = disp_hold_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Directed bench for stopwatch_ctrl with CLK_HZ=1000, TICK_HZ=100 (DIV=10)
// and DEBOUNCE_CYCLES=4. Two instances share all inputs: one stops at 99,
// the other wraps. Inputs are driven on the falling edge, outputs are logged
// per rising-edge count on the falling edge and checked against hand-derived
// cycle numbers.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    localparam int DEB   = 4;
    localparam int DIV   = 10;
    localparam int LOG_N = 8192;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_LAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic       clk_50mhz = 1'b0;
    logic       rst;
    logic       btn_ss;
    logic       btn_lc;
    logic       at_max;
    logic       cnt_tick, cnt_clr, lap_load, disp_hold;
    logic [2:0] state;
    logic       w_tick, w_clr, w_lap, w_hold;
    logic [2:0] w_state;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int act_cyc = 0;
    int wide_ticks = 0;
    bit prev_tick = 1'b0;

    logic [2:0] st_log   [0:LOG_N-1];
    bit         tick_log [0:LOG_N-1];
    bit         clr_log  [0:LOG_N-1];
    bit         lap_log  [0:LOG_N-1];
    bit         hold_log [0:LOG_N-1];

    stopwatch_ctrl #(
        .CLK_HZ (1000), .TICK_HZ (100), .DEBOUNCE_CYCLES (DEB), .WRAP (0)
    ) dut (
        .clk_50mhz (clk_50mhz), .rst (rst), .btn_ss (btn_ss), .btn_lc (btn_lc),
        .at_max (at_max), .cnt_tick (cnt_tick), .cnt_clr (cnt_clr),
        .lap_load (lap_load), .disp_hold (disp_hold), .state (state)
    );

    stopwatch_ctrl #(
        .CLK_HZ (1000), .TICK_HZ (100), .DEBOUNCE_CYCLES (DEB), .WRAP (1)
    ) dut_w (
        .clk_50mhz (clk_50mhz), .rst (rst), .btn_ss (btn_ss), .btn_lc (btn_lc),
        .at_max (at_max), .cnt_tick (w_tick), .cnt_clr (w_clr),
        .lap_load (w_lap), .disp_hold (w_hold), .state (w_state)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    // Rising-edge counter: a value logged at index k is what the outputs
    // held right after rising edge number k.
    always @(posedge clk_50mhz) cyc <= cyc + 1;

    always @(negedge clk_50mhz) begin
        if (cyc < LOG_N) begin
            st_log[cyc]   = state;
            tick_log[cyc] = cnt_tick;
            clr_log[cyc]  = cnt_clr;
            lap_log[cyc]  = lap_load;
            hold_log[cyc] = disp_hold;
        end
        if (cnt_tick && prev_tick) wide_ticks++;
        prev_tick = cnt_tick;
    end

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count logged pulses in the window (lo, hi]; which: 0 tick, 1 clr, 2 lap.
    function automatic int countLog(input int which, input int lo, input int hi);
        int n = 0;
        for (int i = lo + 1; i <= hi && i < LOG_N; i++) begin
            if (i >= 0) begin
                case (which)
                    0:       n += int'(tick_log[i]);
                    1:       n += int'(clr_log[i]);
                    default: n += int'(lap_log[i]);
                endcase
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Clean press: held long enough to be accepted, then released and left
    // alone until the release has been debounced. act_cyc is the edge at
    // which the state machine reacts.
    task automatic applyStimulus(input logic ss, input logic lc);
        @(negedge clk_50mhz);
        btn_ss  = ss;
        btn_lc  = lc;
        act_cyc = cyc + 1 + DEB + 3;
        repeat (DEB + 4) @(negedge clk_50mhz);
        btn_ss = 1'b0;
        btn_lc = 1'b0;
        repeat (DEB + 8) @(negedge clk_50mhz);
    endtask

    initial begin
        int         n_cyc, run_start, pause_cyc, phase, resume_cyc, first_due;
        int         lap_cyc, run2_cyc, tick_at, done_cyc, rst_cyc, grid;
        bit         got;
        logic       tick_s, w_tick_s;
        logic [2:0] w_state_s;
        logic [8:0] glitch;

        rst = 1'b1; btn_ss = 1'b0; btn_lc = 1'b0; at_max = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        checkOutput("rst_state", state, S_IDLE);
        checkOutput("rst_tick", cnt_tick, 0);
        checkOutput("rst_clr", cnt_clr, 0);
        checkOutput("rst_lap", lap_load, 0);
        checkOutput("rst_hold", disp_hold, 0);
        @(negedge clk_50mhz);
        rst = 1'b0;
        repeat (3) @(negedge clk_50mhz);

        // --- Debounce and latency ---
        $display("[TB] debounce and latency");
        glitch = 9'b0_0011_0011;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_50mhz);
            btn_ss = glitch[i];
        end
        @(negedge clk_50mhz);
        btn_ss = 1'b1;
        n_cyc  = cyc + 1;
        repeat (40) @(negedge clk_50mhz);
        checkOutput("deb_before", st_log[n_cyc + DEB + 2], S_IDLE);
        checkOutput("deb_latency", st_log[n_cyc + DEB + 3], S_RUN);
        checkOutput("deb_one_press", state, S_RUN);
        run_start = n_cyc + DEB + 3;
        btn_ss = 1'b0;
        repeat (20) @(negedge clk_50mhz);
        checkOutput("release_no_event", state, S_RUN);

        // --- Tick rate, pause and phase ---
        $display("[TB] tick rate and pause");
        while (cyc < run_start + 105) @(negedge clk_50mhz);
        checkOutput("tick_count", countLog(0, run_start, run_start + 100), 10);
        grid = 0;
        for (int k = 1; k <= 10; k++) grid += int'(tick_log[run_start + DIV * k]);
        checkOutput("tick_on_grid", grid, 10);

        applyStimulus(1'b1, 1'b0);
        pause_cyc = act_cyc;
        checkOutput("pause_before", st_log[pause_cyc - 1], S_RUN);
        checkOutput("pause_enter", st_log[pause_cyc], S_PAUSE);
        phase = (pause_cyc - run_start) % DIV;
        repeat (15) @(negedge clk_50mhz);

        applyStimulus(1'b1, 1'b0);
        resume_cyc = act_cyc;
        checkOutput("resume_run", st_log[resume_cyc], S_RUN);
        checkOutput("pause_no_tick", countLog(0, pause_cyc, resume_cyc), 0);
        first_due = resume_cyc + DIV - phase;
        while (cyc < first_due + 2) @(negedge clk_50mhz);
        checkOutput("resume_phase", tick_log[first_due], 1);
        checkOutput("resume_early", countLog(0, resume_cyc, first_due - 1), 0);

        // --- Lap ---
        $display("[TB] lap");
        applyStimulus(1'b0, 1'b1);
        lap_cyc = act_cyc;
        checkOutput("lap_enter", st_log[lap_cyc], S_LAP);
        checkOutput("lap_load_at", lap_log[lap_cyc], 1);
        checkOutput("lap_single", countLog(2, lap_cyc - 5, lap_cyc + 10), 1);
        checkOutput("lap_hold_pre", hold_log[lap_cyc - 1], 0);
        checkOutput("lap_hold", hold_log[lap_cyc], 1);
        applyStimulus(1'b0, 1'b1);
        run2_cyc = act_cyc;
        checkOutput("lap_exit", st_log[run2_cyc], S_RUN);
        checkOutput("lap_exit_hold", hold_log[run2_cyc], 0);
        checkOutput("lap_hold_kept", hold_log[run2_cyc - 1], 1);
        checkOutput("lap_ticks", countLog(0, lap_cyc, lap_cyc + 20), 2);

        // --- Terminal count, both stop and wrap variants ---
        $display("[TB] terminal count");
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk_50mhz);
            if (cnt_tick) got = 1'b1;
        end
        checkOutput("tick_seen", got, 1);
        tick_at = cyc;
        at_max  = 1'b1;
        done_cyc = -1;
        tick_s = 1'b1; w_tick_s = 1'b0; w_state_s = S_IDLE;
        for (int i = 0; i < 15 && done_cyc < 0; i++) begin
            @(negedge clk_50mhz);
            if (state == S_DONE) begin
                done_cyc  = cyc;
                tick_s    = cnt_tick;
                w_tick_s  = w_tick;
                w_state_s = w_state;
            end
        end
        checkOutput("done_at_terminal", done_cyc, tick_at + DIV);
        checkOutput("done_no_tick", tick_s, 0);
        checkOutput("done_hold", disp_hold, 0);
        checkOutput("wrap_tick", w_tick_s, 1);
        checkOutput("wrap_stays_run", w_state_s, S_RUN);

        applyStimulus(1'b1, 1'b0);
        checkOutput("done_ignores_ss", st_log[act_cyc], S_DONE);
        checkOutput("done_no_ticks", countLog(0, done_cyc, act_cyc + 5), 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("done_clear_idle", st_log[act_cyc], S_IDLE);
        checkOutput("done_clr_at", clr_log[act_cyc], 1);
        checkOutput("done_clr_single", countLog(1, done_cyc, act_cyc + 10), 1);
        at_max = 1'b0;

        // --- Simultaneous presses ---
        $display("[TB] simultaneous presses");
        applyStimulus(1'b1, 1'b0);
        checkOutput("simul_pre_run", st_log[act_cyc], S_RUN);
        applyStimulus(1'b1, 1'b1);
        checkOutput("simul_pause", st_log[act_cyc], S_PAUSE);
        checkOutput("simul_no_lap", countLog(2, act_cyc - 3, act_cyc + 5), 0);
        checkOutput("simul_hold", hold_log[act_cyc], 0);

        // --- Reset in the middle of a lap ---
        $display("[TB] reset during lap");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("pre_reset_lap", state, S_LAP);
        checkOutput("pre_reset_hold", disp_hold, 1);
        @(negedge clk_50mhz);
        rst = 1'b1;
        @(negedge clk_50mhz);
        rst = 1'b0;
        rst_cyc = cyc;
        checkOutput("mid_rst_state", state, S_IDLE);
        checkOutput("mid_rst_hold", disp_hold, 0);
        checkOutput("mid_rst_tick", cnt_tick, 0);
        checkOutput("mid_rst_clr", cnt_clr, 0);
        checkOutput("mid_rst_lap", lap_load, 0);
        repeat (40) @(negedge clk_50mhz);
        checkOutput("post_rst_no_tick", countLog(0, rst_cyc, cyc - 1), 0);
        checkOutput("post_rst_idle", state, S_IDLE);
        applyStimulus(1'b1, 1'b0);
        checkOutput("post_rst_run", st_log[act_cyc], S_RUN);
        while (cyc < act_cyc + DIV + 2) @(negedge clk_50mhz);
        checkOutput("post_rst_first_tick", tick_log[act_cyc + DIV], 1);
        checkOutput("post_rst_early", countLog(0, act_cyc, act_cyc + DIV - 1), 0);

        checkOutput("tick_width", wide_ticks, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control sequencer for the two-digit 0-99 BCD stopwatch counter and its multiplexed 7-segment display.
- Debounces the two raw push-buttons and runs an IDLE/RUN/PAUSE/LAP/DONE state machine.
- Generates the 100 Hz count-enable pulses, clear pulses and lap-freeze control for the counter and display path.
- Replaces free-running clk-divided counting with one-cycle enables in the clk_50mhz domain.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 100, count-enable rate; DIV = CLK_HZ/TICK_HZ (must be an integer >= 2)
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a new button level (10 ms)
WRAP, 0, 1 = counter wraps 99->00 and keeps running; 0 = stop at 99 and enter DONE

Ports:
clk_50mhz  in   1  system clock; single clock domain
rst        in   1  synchronous, active-high reset
btn_ss     in   1  raw start/stop button, active-high, asynchronous to clk_50mhz
btn_lc     in   1  raw lap/clear button, active-high, asynchronous to clk_50mhz
at_max     in   1  counter reports value 99
cnt_tick   out  1  one-cycle count enable to the units counter
cnt_clr    out  1  one-cycle counter clear
lap_load   out  1  one-cycle pulse: display latches the current count
disp_hold  out  1  display shows the latched lap value instead of the live count
state      out  3  IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4

Behaviour:
- All outputs are registered. On rst: state=IDLE, all other outputs 0, divider=0, debounced levels=0, synchronizers=0. Reset mid-operation aborts any state; counter contents are not cleared by this block on reset.
- Button path, per button:
  - 2-FF synchronizer.
  - Stability counter: the debounced level updates only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current debounced level. Any bounce restarts the count.
  - Press event = rising edge of the debounced level, one cycle wide.
  - Releases generate no event.
  - Fixed latency: a clean raw rising edge sampled at cycle N changes state/outputs at the edge ending cycle N+DEBOUNCE_CYCLES+3.
  - A button held through reset yields one press once debounced after reset.
- Simultaneous ss and lc press events in the same cycle: ss is acted on, lc is discarded.
- FSM transitions (ss = ss press, lc = lc press):
  - IDLE:
    - ss -> RUN, divider cleared to 0.
    - lc -> stay IDLE, cnt_clr=1 for one cycle.
  - RUN:
    - ss -> PAUSE.
    - lc -> LAP, lap_load=1 for one cycle, disp_hold=1.
  - LAP: counting continues.
    - ss -> PAUSE, disp_hold=0.
    - lc -> RUN, disp_hold=0.
  - PAUSE: divider holds its value, so phase is preserved.
    - ss -> RUN.
    - lc -> IDLE, cnt_clr=1.
  - DONE:
    - lc -> IDLE, cnt_clr=1.
    - ss ignored.
- Tick generation, in RUN and LAP only:
  - Divider counts 0..DIV-1.
  - When divider==DIV-1, it wraps to 0 and cnt_tick=1 next cycle, unless WRAP=0 and at_max=1. In that case there is no tick, state -> DONE and disp_hold -> 0; the counter stays at 99.
  - Gap between consecutive ticks is exactly DIV cycles.
- A button event and a divider terminal in the same cycle:
  - The tick is still issued if the current state is RUN/LAP; the transition happens too.
  - Leaving to PAUSE still emits that final tick.
  - With WRAP=0 and at_max=1, the max check wins over a concurrent lc in RUN/LAP (go DONE).
- cnt_clr, lap_load and cnt_tick never overlap with a tick caused by a clear in the same cycle: a clear only occurs from IDLE, PAUSE or DONE, where ticks are inactive.

Test Plan:
Use CLK_HZ=1000, TICK_HZ=100 (DIV=10), DEBOUNCE_CYCLES=4, WRAP=0 unless stated.
1. Debounce/latency: btn_ss pulses 1-0-1 with 2-cycle glitches, then held high from cycle 100 -> no state change before cycle 107; state=RUN at 100+4+3; exactly one press event.
2. Tick rate: RUN for 100 cycles -> cnt_tick pulses exactly every 10 cycles, one cycle wide; ss press -> PAUSE, ticks stop; ss again -> first tick arrives after the remaining divider cycles (phase preserved).
3. Lap: in RUN press lc -> state=LAP, lap_load single pulse, disp_hold=1, ticks continue; lc again -> RUN, disp_hold=0.
4. Terminal: at_max=1 in RUN at divider terminal -> no cnt_tick, state=DONE; ss ignored; lc -> IDLE with one cnt_clr pulse. Repeat with WRAP=1 -> tick issued, stays RUN.
5. Simultaneous: ss and lc debounced in the same cycle from RUN -> state=PAUSE, no lap_load.
6. Reset mid-LAP: assert rst one cycle -> next cycle state=IDLE, disp_hold=0, all pulses 0, no ticks until ss press.
